// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy-derived flow-control flags.
// The head entry is visible on dout whenever the queue holds data, so a consumer reads with zero latency.
module fifo #(
  parameter int DBITS = 32,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             half_full,
  output logic             almost_empty
);

  localparam int DEPTH = 1 << SIZE;
  localparam int CW    = SIZE + 1;

  localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_AFULL = CW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(DEPTH / 2);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [SIZE-1:0] PTR_ONE   = SIZE'(1);

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [SIZE-1:0]  wptr_q, wptr_d;
  logic [SIZE-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // A write into a full queue is still accepted when the same edge frees a slot.
  always_comb begin
    wr_acc_s = wr && (!full || rd);
    rd_acc_s = rd && !empty;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    if (wr_acc_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_acc_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state; clearing these is enough to hide any stale storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= {SIZE{1'b0}};
      rptr_q <= {SIZE{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array, deliberately without reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign empty        = (cnt_q == {CW{1'b0}});
  assign full         = (cnt_q == CNT_FULL);
  assign almost_full  = (cnt_q >= CNT_AFULL);
  assign half_full    = (cnt_q >= CNT_HALF);
  assign almost_empty = (cnt_q <= CNT_ONE);

  assign dout = empty ? {DBITS{1'b0}} : mem_q[rptr_q];

endmodule

// File: tb/tb_fifo.sv
// Directed and randomized scoreboard bench for fifo: a small 8x4 instance for the
// corner cases and a 480-bit x16 instance for wrap-around, ordering and mid-stream reset.
module tb_fifo;

  logic clk;
  logic reset;

  logic         s_wr, s_rd;
  logic [7:0]   s_din, s_dout;
  logic         s_empty, s_full, s_afull, s_half, s_aempty;

  logic         b_wr, b_rd;
  logic [479:0] b_din, b_dout;
  logic         b_empty, b_full, b_afull, b_half, b_aempty;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0]   sq[$];
  logic [479:0] bq[$];
  int scnt = 0;
  int bcnt = 0;

  fifo #(.DBITS(8), .SIZE(2)) u_s (
    .clk(clk), .reset(reset), .wr(s_wr), .rd(s_rd), .din(s_din), .dout(s_dout),
    .empty(s_empty), .full(s_full), .almost_full(s_afull), .half_full(s_half),
    .almost_empty(s_aempty)
  );

  fifo #(.DBITS(480), .SIZE(4)) u_b (
    .clk(clk), .reset(reset), .wr(b_wr), .rd(b_rd), .din(b_din), .dout(b_dout),
    .empty(b_empty), .full(b_full), .almost_full(b_afull), .half_full(b_half),
    .almost_empty(b_aempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected order: {empty, almost_empty, half_full, almost_full, full}.
  function automatic logic [4:0] exp_flags(input int cnt, input int depth);
    logic [4:0] f;
    f[4] = (cnt == 0);
    f[3] = (cnt <= 1);
    f[2] = (cnt >= depth / 2);
    f[1] = (cnt >= depth - 1);
    f[0] = (cnt == depth);
    return f;
  endfunction

  function automatic logic [479:0] rand_word();
    logic [479:0] v;
    for (int k = 0; k < 15; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_check(input string tag);
    logic [7:0] e;
    e = (scnt == 0) ? 8'h00 : sq[0];
    chk({tag, "_flags"}, {475'd0, s_empty, s_aempty, s_half, s_afull, s_full}, {475'd0, exp_flags(scnt, 4)});
    chk({tag, "_dout"}, {472'd0, s_dout}, {472'd0, e});
  endtask

  task automatic s_cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
    logic wacc, racc;
    s_wr = w; s_rd = r; s_din = d;
    wacc = w && ((scnt != 4) || r);
    racc = r && (scnt != 0);
    #1;
    // Zero-latency read: dout before the edge must already be the head.
    chk({tag, "_pre"}, {472'd0, s_dout}, {472'd0, (scnt == 0) ? 8'h00 : sq[0]});
    tick();
    if (racc) void'(sq.pop_front());
    if (wacc) sq.push_back(d);
    scnt = scnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
    s_check(tag);
  endtask

  task automatic b_check(input string tag);
    chk({tag, "_flags"}, {475'd0, b_empty, b_aempty, b_half, b_afull, b_full}, {475'd0, exp_flags(bcnt, 16)});
    chk({tag, "_dout"}, b_dout, (bcnt == 0) ? 480'd0 : bq[0]);
  endtask

  task automatic b_cycle(input logic w, input logic r, input logic [479:0] d, output logic wacc);
    logic racc;
    b_wr = w; b_rd = r; b_din = d;
    wacc = w && ((bcnt != 16) || r);
    racc = r && (bcnt != 0);
    chk("b_pre", b_dout, (bcnt == 0) ? 480'd0 : bq[0]);
    tick();
    if (racc) void'(bq.pop_front());
    if (wacc) bq.push_back(d);
    bcnt = bcnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    b_wr = 1'b0; b_rd = 1'b0;
    b_check("b_post");
  endtask

  initial begin
    int  written;
    int  cyc;
    bit  did_reset;
    logic acc;

    reset = 1'b0;
    s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
    b_wr = 1'b0; b_rd = 1'b0; b_din = 480'd0;
    tick();
    tick();
    s_check("rst_hold");
    b_check("b_rst_hold");
    reset = 1'b1;
    tick();
    s_check("rst_rel");

    // Fill 0xA..0xD; the flag staircase is checked after every write.
    for (int i = 0; i < 4; i++) s_cycle("fill", 1'b1, 1'b0, 8'h0A + 8'(i));
    chk("fill_head", {472'd0, s_dout}, {472'd0, 8'h0A});

    s_cycle("ovf", 1'b1, 1'b0, 8'h0E);
    for (int i = 0; i < 4; i++) s_cycle("drain1", 1'b0, 1'b1, 8'h00);
    chk("drain1_empty", {479'd0, s_empty}, 480'd1);

    s_cycle("udf", 1'b0, 1'b1, 8'h00);
    s_cycle("rw_empty", 1'b1, 1'b1, 8'h05);
    chk("rw_empty_d", {472'd0, s_dout}, {472'd0, 8'h05});
    s_cycle("rw_one", 1'b1, 1'b1, 8'h06);
    chk("rw_one_d", {472'd0, s_dout}, {472'd0, 8'h06});
    s_cycle("drain2", 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 4; i++) s_cycle("fill2", 1'b1, 1'b0, 8'h0A + 8'(i));
    s_cycle("rw_full", 1'b1, 1'b1, 8'h0E);
    chk("rw_full_f", {479'd0, s_full}, 480'd1);
    chk("rw_full_d", {472'd0, s_dout}, {472'd0, 8'h0B});
    for (int i = 0; i < 4; i++) s_cycle("drain3", 1'b0, 1'b1, 8'h00);

    // Randomized 480-bit stream with a reset pulse partway through.
    written = 0;
    cyc = 0;
    did_reset = 1'b0;
    while (written < 40 && cyc < 3000) begin
      if (written == 20 && !did_reset) begin
        did_reset = 1'b1;
        reset = 1'b0;
        #1;
        bq.delete();
        bcnt = 0;
        b_check("b_midrst");
        tick();
        reset = 1'b1;
        tick();
        b_check("b_rel");
      end
      b_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_word(), acc);
      if (acc) written++;
      cyc++;
    end
    chk("b_stream_done", {479'd0, written >= 40}, 480'd1);
    cyc = 0;
    while (bcnt > 0 && cyc < 100) begin
      b_cycle(1'b0, 1'b1, 480'd0, acc);
      cyc++;
    end
    chk("b_drained", {479'd0, b_empty}, 480'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
